adc_seq: RTL
============

# adc_seq

Sampling sequencer for the `adc` macro, driving its `start`/`ready`/`data_out` handshake. It issues conversion requests at a programmable interval and captures each result. Results are optionally averaged over 2^AVG_LOG2 conversions. Each result is presented to the digital core through a valid/ready output register with overrun and timeout flags.

## Interface
Parameters:
- DATA_W, 8, conversion width; matches the ADC `data_out`
- PERIOD_W, 16, width of the `period` input
- AVG_LOG2, 2, log2 of the number of conversions averaged per result
- TIMEOUT, 15, maximum cycles spent in WAIT_RDY before abort; range 1..255

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  run the sequencer; 0 forces IDLE
- period  in  PERIOD_W  idle cycles between conversions; sampled when entering WAIT
- adc_start  out  1  one-cycle conversion request, connects to ADC `start`
- adc_ready  in  1  conversion-done strobe, from ADC `ready`
- adc_data  in  DATA_W  conversion result, from ADC `data_out`; valid while adc_ready=1
- sample_data  out  DATA_W  result register
- sample_valid  out  1  result available
- sample_ready  in  1  consumer accepts the result
- overrun  out  1  one-cycle pulse: a result was dropped because the output register was still full
- timeout_err  out  1  one-cycle pulse: no adc_ready within TIMEOUT cycles

## Operation
- Reset (rst_n=0 at an edge):
  - state=IDLE
  - all outputs 0
  - accumulator, sample count, period counter and timeout counter cleared
- IDLE:
  - adc_start=0
  - enable=1 → WAIT with period counter loaded from `period`
- WAIT:
  - counter decrements each cycle
  - count==0 → START
  - period=0 gives exactly one WAIT cycle
- START:
  - adc_start=1 for exactly this cycle
  - timeout counter loaded with TIMEOUT
  - → WAIT_RDY
- WAIT_RDY, adc_ready=1:
  - capture adc_data, add to accumulator (width DATA_W+AVG_LOG2, no overflow possible), increment sample count
  - count reaches 2^AVG_LOG2 → result = accumulator >> AVG_LOG2 (truncating); accumulator and count cleared; result offered to the output register
  - → WAIT, period reloaded
- WAIT_RDY, adc_ready=0:
  - timeout counter decrements
  - counter at 0 → timeout_err pulse; this conversion discarded, partial accumulation kept; → WAIT
- adc_ready outside WAIT_RDY is ignored.
- Output register:
  - Offered result with sample_valid=0, or with sample_valid=1 and sample_ready=1 in the same cycle → load sample_data, sample_valid=1.
  - Offered result with sample_valid=1 and sample_ready=0 → result dropped, overrun=1 for one cycle, held data unchanged.
  - sample_ready=1 with no new result → sample_valid=0 next cycle.
- enable=0 in any non-IDLE state:
  - → IDLE next edge
  - accumulator and count cleared
  - in-flight conversion abandoned
  - output register and its handshake unaffected, so a pending result is still delivered
- enable held 1 → continuous operation, no return to IDLE.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- Against the stub ADC (ready = start delayed one cycle): adc_start pulses every period+3 cycles (WAIT period+1, START 1, WAIT_RDY 1).
- adc_data is captured at the edge where adc_ready=1 is seen.
- Result latency: sample_valid rises 1 cycle after the capture edge of the final conversion of a group.
- timeout_err asserts TIMEOUT+1 cycles after the START cycle.
- overrun and timeout_err are never held longer than one cycle.

## Configuration
- ADC_SEQ_AVG_EN defined: averaging as described; each result covers 2^AVG_LOG2 conversions.
- ADC_SEQ_AVG_EN undefined:
  - AVG_LOG2 ignored; no accumulator is built
  - every captured adc_data is offered directly to the output register
  - timeout discards only the current conversion

## Test plan
- Reset, then enable=1, period=4, stub ADC with adc_data=8'h40 → adc_start pulses every 7 cycles; sample_valid first rises with sample_data=8'h40 (AVG_EN, 4 conversions); sample_ready=1 throughout.
- AVG_EN, adc_data sequence 8'h10, 8'h11, 8'h12, 8'h14 → sample_data=8'h11 (sum 0x47 >> 2); all 8'hFF → 8'hFF.
- sample_ready=0 held across two results → first result held, overrun pulses once, sample_data unchanged; then sample_ready=1 → sample_valid=0 next cycle.
- adc_ready tied 0, TIMEOUT=15 → timeout_err pulses 16 cycles after each adc_start; sample_valid stays 0.
- enable dropped one cycle after the second adc_start of a group → IDLE, no adc_start while disabled; re-enable → next result averages four fresh conversions only.
- rst_n=0 mid-WAIT_RDY with sample_valid=1 → all outputs 0 on the next edge, state IDLE.

Source files
------------

// File: rtl/adc_seq.sv
// adc_seq: paced ADC conversion sequencer feeding a valid/ready result register.
// Define ADC_SEQ_AVG_EN to average each result over 2^AVG_LOG2 conversions.
module adc_seq #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                adc_start,
  input  logic                adc_ready,
  input  logic [DATA_W-1:0]   adc_data,
  output logic [DATA_W-1:0]   sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned ToW = 8;

  if (TIMEOUT < 1 || TIMEOUT > 255 || AVG_LOG2 > 16) begin : g_param_check
    $error("adc_seq: TIMEOUT must be 1..255 and AVG_LOG2 at most 16");
  end

  typedef enum logic [1:0] {StIdle, StWait, StStart, StWaitRdy} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [ToW-1:0]      to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                offer_q, offer_d;
  logic                capture, timeout_d;
  logic [DATA_W-1:0]   sample_data_d;
  logic                sample_valid_d, overrun_d;

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    to_cnt_d  = to_cnt_q;
    capture   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d   = StWait;
          per_cnt_d = period;
        end
      end
      StWait: begin
        if (per_cnt_q == '0) begin
          state_d = StStart;
        end else begin
          per_cnt_d = per_cnt_q - 1'b1;
        end
      end
      StStart: begin
        state_d  = StWaitRdy;
        to_cnt_d = ToW'(TIMEOUT);
      end
      StWaitRdy: begin
        if (adc_ready) begin
          capture   = 1'b1;
          state_d   = StWait;
          per_cnt_d = period;
        end else if (to_cnt_q == ToW'(1)) begin
          // Last permitted WAIT_RDY cycle ran out: abort this conversion.
          timeout_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = StWait;
          per_cnt_d = period;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!enable) begin
      state_d   = StIdle;
      capture   = 1'b0;
      timeout_d = 1'b0;
    end
  end

`ifdef ADC_SEQ_AVG_EN
  localparam int unsigned AccW = DATA_W + AVG_LOG2;
  localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [AccW-1:0] acc_q, acc_d, acc_sum;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    offer_d = 1'b0;
    acc_sum = acc_q + AccW'(adc_data);
    if (capture) begin
      if (cnt_q == CntW'((1 << AVG_LOG2) - 1)) begin
        res_d   = DATA_W'(acc_sum >> AVG_LOG2);
        offer_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    res_d   = capture ? adc_data : res_q;
    offer_d = capture;
  end
`endif

  // Output register: a new result may replace one being accepted this same cycle.
  always_comb begin
    sample_data_d  = sample_data;
    sample_valid_d = sample_valid;
    overrun_d      = 1'b0;
    if (offer_q) begin
      if (!sample_valid || sample_ready) begin
        sample_data_d  = res_q;
        sample_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (sample_ready) begin
      sample_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      per_cnt_q    <= '0;
      to_cnt_q     <= '0;
      res_q        <= '0;
      offer_q      <= 1'b0;
      adc_start    <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      to_cnt_q     <= to_cnt_d;
      res_q        <= res_d;
      offer_q      <= offer_d;
      adc_start    <= (state_d == StStart);
      sample_data  <= sample_data_d;
      sample_valid <= sample_valid_d;
      overrun      <= overrun_d;
      timeout_err  <= timeout_d;
    end
  end

endmodule
